// File: rtl/key_arpeggiator.sv
// key_arpeggiator: steps through held keypad keys at a tick-based tempo, emitting keycode/gate/step.
// Optional latch mode (hold last chord after release) is enabled by defining ARP_LATCH_EN.
module key_arpeggiator #(
   parameter int NUM_KEYS = 14,
   parameter int TICK_W   = 16
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NUM_KEYS-1:0] keypad_i,
   input  logic                sample_now,
   input  logic [1:0]          arp_mode,
   input  logic [TICK_W-1:0]   step_period,
   input  logic [TICK_W-1:0]   gate_len,
   output logic [3:0]          keycode,
   output logic                note_on,
   output logic                step
);
   typedef enum logic {IDLE, PLAY} state_t;
   state_t              state_q, state_d;
   logic [NUM_KEYS-1:0] held_q, mask;
   logic [3:0]          keycode_q, keycode_d, nxt_key, start_key;
   logic [3:0]          up_idx, dn_idx, lo_idx, hi_idx;
   logic [1:0]          mode_q, mode_d;
   logic [TICK_W-1:0]   tick_q, tick_d, per_m1;
   logic                note_q, note_d, step_q, step_d, dir_q, dir_d, nxt_dir;
   logic                up_ok, dn_ok, ud_down, adv, restart;
`ifdef ARP_LATCH_EN
   logic [NUM_KEYS-1:0] latch_q;
   logic                prev_nz_q;
   assign mask    = |held_q ? held_q : latch_q;
   assign restart = |held_q && !prev_nz_q;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         latch_q   <= '0;
         prev_nz_q <= 1'b0;
      end else begin
         latch_q   <= |held_q ? held_q : latch_q;
         prev_nz_q <= |held_q;
      end
`else
   assign mask    = held_q;
   assign restart = 1'b0;
`endif
   // Nearest set bits above/below the current (possibly stale) index, plus the extremes.
   always_comb begin
      up_ok  = 1'b0;
      dn_ok  = 1'b0;
      up_idx = '0;
      dn_idx = '0;
      lo_idx = '0;
      hi_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (mask[i]) begin
            lo_idx = 4'(i);
            if (4'(i) > keycode_q) begin
               up_ok  = 1'b1;
               up_idx = 4'(i);
            end
         end
      for (int i = 0; i < NUM_KEYS; i++)
         if (mask[i]) begin
            hi_idx = 4'(i);
            if (4'(i) < keycode_q) begin
               dn_ok  = 1'b1;
               dn_idx = 4'(i);
            end
         end
   end
   assign per_m1    = (step_period == '0) ? '0 : step_period - 1'b1;
   assign adv       = sample_now && (tick_q >= per_m1);
   assign start_key = (arp_mode == 2'b01) ? hi_idx : lo_idx;
   // Direction only persists while staying in up-down; entering it starts upward.
   assign ud_down   = (mode_q == 2'b10) && dir_q;
   always_comb begin
      nxt_key = up_ok ? up_idx : lo_idx;
      nxt_dir = 1'b0;
      if (arp_mode == 2'b01)
         nxt_key = dn_ok ? dn_idx : hi_idx;
      else if (arp_mode == 2'b10 && !ud_down) begin
         nxt_key = up_ok ? up_idx : (dn_ok ? dn_idx : lo_idx);
         nxt_dir = !up_ok && dn_ok;
      end else if (arp_mode == 2'b10) begin
         nxt_key = dn_ok ? dn_idx : (up_ok ? up_idx : lo_idx);
         nxt_dir = dn_ok || !up_ok;
      end
   end
   always_comb begin
      state_d   = state_q;
      keycode_d = keycode_q;
      note_d    = note_q;
      step_d    = 1'b0;
      dir_d     = dir_q;
      tick_d    = tick_q;
      mode_d    = mode_q;
      if ((state_q == IDLE || restart) && |mask) begin
         state_d   = PLAY;
         keycode_d = start_key;
         note_d    = 1'b1;
         step_d    = 1'b1;
         tick_d    = '0;
         dir_d     = 1'b0;
         mode_d    = arp_mode;
      end else if (state_q == PLAY && !(|mask)) begin
         state_d   = IDLE;
         keycode_d = 4'hF;
         note_d    = 1'b0;
         dir_d     = 1'b0;
         tick_d    = '0;
      end else if (state_q == PLAY && adv) begin
         keycode_d = nxt_key;
         note_d    = 1'b1;
         step_d    = 1'b1;
         tick_d    = '0;
         dir_d     = nxt_dir;
         mode_d    = arp_mode;
      end else if (state_q == PLAY) begin
         tick_d = sample_now ? tick_q + 1'b1 : tick_q;
         note_d = note_q && mask[keycode_q] && (tick_d < gate_len);
      end
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state_q   <= IDLE;
         held_q    <= '0;
         keycode_q <= 4'hF;
         note_q    <= 1'b0;
         step_q    <= 1'b0;
         dir_q     <= 1'b0;
         tick_q    <= '0;
         mode_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         held_q    <= keypad_i;
         keycode_q <= keycode_d;
         note_q    <= note_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         tick_q    <= tick_d;
         mode_q    <= mode_d;
      end
   assign keycode = keycode_q;
   assign note_on = note_q;
   assign step    = step_q;
endmodule

// File: tb/tb_key_arpeggiator.sv
// tb_key_arpeggiator: directed scenario tasks with hand-computed expectations for key_arpeggiator.
module tb_key_arpeggiator;
   logic        clk = 1'b0, n_rst = 1'b0, sample_now = 1'b0;
   logic [13:0] keypad_i = '0;
   logic [1:0]  arp_mode = 2'b00;
   logic [15:0] step_period = 16'd4, gate_len = 16'd2;
   logic [3:0]  keycode;
   logic        note_on, step;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   key_arpeggiator dut (
      .clk(clk), .n_rst(n_rst), .keypad_i(keypad_i), .sample_now(sample_now),
      .arp_mode(arp_mode), .step_period(step_period), .gate_len(gate_len),
      .keycode(keycode), .note_on(note_on), .step(step)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample_now = 1'b1;
      cyc(1);
      sample_now = 1'b0;
   endtask

   task automatic go_idle();
      keypad_i = '0;
      cyc(2);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      keypad_i = 14'h0024;
      cyc(3);
      total++; if (keycode !== 4'hF) begin bad++; $display("FAIL rst_keycode got=%h exp=f", keycode); end
      total++; if (note_on !== 1'b0) begin bad++; $display("FAIL rst_note got=%b exp=0", note_on); end
      total++; if (step !== 1'b0) begin bad++; $display("FAIL rst_step got=%b exp=0", step); end
      n_rst = 1'b1;
      cyc(2);
      total++; if (keycode !== 4'd2 || step !== 1'b1 || note_on !== 1'b1) begin bad++; $display("FAIL rst_start got=%h/%b/%b exp=2/1/1", keycode, step, note_on); end
      #2 n_rst = 1'b0;
      #1;
      total++; if (keycode !== 4'hF || note_on !== 1'b0 || step !== 1'b0) begin bad++; $display("FAIL async_rst got=%h/%b/%b exp=f/0/0", keycode, note_on, step); end
      keypad_i = '0;
      cyc(1);
      n_rst = 1'b1;
      cyc(1);
   endtask

   task automatic test_up();
      logic [3:0] exp_k[3] = '{4'd5, 4'd9, 4'd2};
      arp_mode = 2'b00; step_period = 16'd4; gate_len = 16'd2;
      keypad_i = 14'h0224;
      cyc(2);
      total++; if (keycode !== 4'd2 || step !== 1'b1 || note_on !== 1'b1) begin bad++; $display("FAIL up_start got=%h/%b/%b exp=2/1/1", keycode, step, note_on); end
      for (int s = 0; s < 3; s++)
         for (int t = 1; t <= 4; t++) begin
            tick();
            total++; if (note_on !== (t == 1 || t == 4)) begin bad++; $display("FAIL up_gate s=%0d t=%0d got=%b exp=%b", s, t, note_on, (t == 1 || t == 4)); end
            total++; if (step !== (t == 4)) begin bad++; $display("FAIL up_step s=%0d t=%0d got=%b exp=%b", s, t, step, (t == 4)); end
            if (t == 4) begin
               total++; if (keycode !== exp_k[s]) begin bad++; $display("FAIL up_key s=%0d got=%h exp=%h", s, keycode, exp_k[s]); end
            end
         end
      go_idle();
      total++; if (keycode !== 4'hF || note_on !== 1'b0) begin bad++; $display("FAIL up_idle got=%h/%b exp=f/0", keycode, note_on); end
   endtask

   task automatic test_updown();
      logic [3:0] exp_k[5] = '{4'd3, 4'd7, 4'd3, 4'd1, 4'd3};
      arp_mode = 2'b10; step_period = 16'd1; gate_len = 16'd1;
      keypad_i = 14'h008A;
      cyc(2);
      total++; if (keycode !== 4'd1) begin bad++; $display("FAIL ud_start got=%h exp=1", keycode); end
      for (int s = 0; s < 5; s++) begin
         tick();
         total++; if (keycode !== exp_k[s] || step !== 1'b1) begin bad++; $display("FAIL ud_key s=%0d got=%h/%b exp=%h/1", s, keycode, step, exp_k[s]); end
      end
      go_idle();
      keypad_i = 14'h0040;
      cyc(2);
      for (int s = 0; s < 3; s++) begin
         total++; if (keycode !== 4'd6 || step !== 1'b1) begin bad++; $display("FAIL single_key s=%0d got=%h/%b exp=6/1", s, keycode, step); end
         tick();
      end
      go_idle();
   endtask

   task automatic test_down_release();
      arp_mode = 2'b01; step_period = 16'd4; gate_len = 16'd8;
      keypad_i = 14'h2001;
      cyc(2);
      total++; if (keycode !== 4'd13) begin bad++; $display("FAIL dn_start got=%h exp=d", keycode); end
      tick();
      keypad_i = 14'h0001;
      cyc(2);
      total++; if (note_on !== 1'b0 || keycode !== 4'd13) begin bad++; $display("FAIL dn_release got=%b/%h exp=0/d", note_on, keycode); end
      tick(); tick();
      total++; if (note_on !== 1'b0 || step !== 1'b0) begin bad++; $display("FAIL dn_wait got=%b/%b exp=0/0", note_on, step); end
      tick();
      total++; if (keycode !== 4'd0 || step !== 1'b1 || note_on !== 1'b1) begin bad++; $display("FAIL dn_next got=%h/%b/%b exp=0/1/1", keycode, step, note_on); end
      repeat (4) tick();
      total++; if (keycode !== 4'd0 || step !== 1'b1) begin bad++; $display("FAIL dn_repeat got=%h/%b exp=0/1", keycode, step); end
      go_idle();
   endtask

   task automatic test_period0();
      logic [3:0] exp_k[3] = '{4'd5, 4'd2, 4'd5};
      arp_mode = 2'b00; step_period = 16'd0; gate_len = 16'd5;
      keypad_i = 14'h0024;
      cyc(2);
      for (int s = 0; s < 3; s++) begin
         tick();
         total++; if (keycode !== exp_k[s] || note_on !== 1'b1) begin bad++; $display("FAIL p0_key s=%0d got=%h/%b exp=%h/1", s, keycode, note_on, exp_k[s]); end
      end
      go_idle();
      total++; if (keycode !== 4'hF || note_on !== 1'b0 || step !== 1'b0) begin bad++; $display("FAIL p0_idle got=%h/%b/%b exp=f/0/0", keycode, note_on, step); end
   endtask

   task automatic test_mode_switch();
      arp_mode = 2'b00; step_period = 16'd1; gate_len = 16'd1;
      keypad_i = 14'h0224;
      cyc(2);
      tick();
      total++; if (keycode !== 4'd5) begin bad++; $display("FAIL ms_up got=%h exp=5", keycode); end
      arp_mode = 2'b10;
      tick();
      total++; if (keycode !== 4'd9) begin bad++; $display("FAIL ms_ud_up got=%h exp=9", keycode); end
      tick();
      total++; if (keycode !== 4'd5) begin bad++; $display("FAIL ms_ud_flip got=%h exp=5", keycode); end
      arp_mode = 2'b01;
      tick();
      total++; if (keycode !== 4'd2) begin bad++; $display("FAIL ms_down got=%h exp=2", keycode); end
      go_idle();
   endtask

   task automatic test_latch();
      arp_mode = 2'b00; step_period = 16'd1; gate_len = 16'd1;
      keypad_i = 14'h0110;
      cyc(2);
      total++; if (keycode !== 4'd4 || step !== 1'b1) begin bad++; $display("FAIL latch_start got=%h/%b exp=4/1", keycode, step); end
      tick();
      keypad_i = '0;
      cyc(2);
      tick();
      total++; if (keycode !== 4'd4 || step !== 1'b1) begin bad++; $display("FAIL latch_hold1 got=%h/%b exp=4/1", keycode, step); end
      tick();
      total++; if (keycode !== 4'd8 || note_on !== 1'b1) begin bad++; $display("FAIL latch_hold2 got=%h/%b exp=8/1", keycode, note_on); end
      keypad_i = 14'h0800;
      cyc(2);
      total++; if (keycode !== 4'd11 || step !== 1'b1) begin bad++; $display("FAIL latch_restart got=%h/%b exp=b/1", keycode, step); end
      tick();
      total++; if (keycode !== 4'd11) begin bad++; $display("FAIL latch_only got=%h exp=b", keycode); end
   endtask

   initial begin
      test_reset();
`ifdef ARP_LATCH_EN
      test_latch();
`else
      test_up();
      test_updown();
      test_down_release();
      test_period0();
      test_mode_switch();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/key_arpeggiator.md
Name: key_arpeggiator

Overview:
- Sequencer placed between the raw keypad inputs and the note path of the synth top level.
- Replaces direct key-to-note encoding: when several of the 14 keys are held, it steps through them one at a time at a programmable tempo.
- Timing base is the existing sample-rate strobe.
- Outputs one keycode per step, plus a gate that the top level uses to mute the PWM output between notes.

Parameters:
- NUM_KEYS, 14, number of keypad lines; keycode is the key index 0..NUM_KEYS-1.
- TICK_W, 16, width of the step_period and gate_len tick counters.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- keypad_i  input  NUM_KEYS  one bit per key, 1 = held; already synchronous to clk.
- sample_now  input  1  one-cycle tick strobe from the sample-rate divider.
- arp_mode  input  2  00 up, 01 down, 10 up-down, 11 treated as up.
- step_period  input  TICK_W  ticks per step; 0 is treated as 1.
- gate_len  input  TICK_W  ticks the gate stays high within a step.
- keycode  output  4  index of the note being played; 4'hF when idle.
- note_on  output  1  gate; high while the current note sounds.
- step  output  1  one-cycle pulse on every note start, including the first.

Behaviour:
- Reset values: keycode=4'hF, note_on=0, step=0, state=IDLE, dir=up, tick_cnt=0, held=0.
- held mask: registered copy of keypad_i, updated every clk (1-cycle latency). All decisions use held, never keypad_i directly.
- States: IDLE, PLAY.
- IDLE -> PLAY: on the cycle held becomes nonzero, load the start note and assert step for 1 cycle. Set note_on=1 and tick_cnt=0 in the same cycle. Start note:
  - up / 11: lowest set index.
  - down: highest set index.
  - up-down: lowest set index, dir=up.
- PLAY tick counting: on each sample_now, tick_cnt++.
- Gate timing:
  - note_on drops on the cycle tick_cnt reaches gate_len.
  - gate_len=0: note_on pulses for the start cycle only.
  - gate_len >= period: note_on stays high through the whole step (legato).
- Step advance: when tick_cnt == max(step_period,1)-1 and sample_now is high, the next cycle does all of the following:
  - tick_cnt=0, load next note, step=1, note_on=1.
- Next-note search, circular over held, excluding the current index unless it is the only set bit:
  - up: next set index strictly above current, wrapping to lowest.
  - down: next set index strictly below current, wrapping to highest.
  - up-down: move in dir. At no further bit in dir, flip dir and take the nearest bit the other way; end notes are not repeated.
  - Single held key: repeats that key each step.
- Current key released mid-step:
  - note_on=0 the cycle after held clears that bit.
  - keycode is held until the next advance.
  - The search starts from the stale index.
- Key added mid-step: no effect until the next advance; it joins the search.
- held becomes 0 in PLAY: next cycle go to IDLE with keycode=4'hF, note_on=0, step=0, dir=up, tick_cnt=0.
- arp_mode change: takes effect at the next advance. Switching into up-down sets dir=up.
- Simultaneous held change and advance in the same cycle: the search uses the updated held.
- step_period / gate_len: sampled live and compared every tick. Lowering step_period below tick_cnt forces an advance on the next sample_now.
- Reset mid-operation: all outputs return to reset values asynchronously.

Optional Feature:
- Macro: ARP_LATCH_EN.
- Defined: latch mode.
  - The play mask holds the last nonzero chord after all keys are released; playback continues.
  - The first press after an all-released interval replaces the mask with the new keys and restarts as IDLE -> PLAY.
  - IDLE is reached only from reset.
- Undefined: the play mask equals held as described above. No extra state is synthesized.

Test Plan:
- Reset with keys held -> keycode=F, note_on=0, step=0 during n_rst=0; first held update then enters PLAY.
- Up mode, step_period=4, gate_len=2, keys 2,5,9 held, continuous ticks -> keycode 2,5,9,2 on every 4th tick, step pulses; note_on high 2 ticks of each 4.
- Up-down mode, keys 1,3,7 -> sequence 1,3,7,3,1,3; single key 6 alone -> 6,6,6.
- Down mode, keys 0,13, then release 13 mid-step -> note_on drops next cycle; next step plays 0, then 0 repeats.
- step_period=0, gate_len=5 -> advance on every tick, note_on continuously high; release all keys -> IDLE, keycode=F within 2 cycles.
- ARP_LATCH_EN defined: press 4,8 then release all -> 4,8 keep cycling; press 11 -> only 11 plays, step pulses on restart.
